imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate generation unit.
- Decodes RV32/RV64 immediates for all base formats, plus shift-amount and CSR zimm modes.
- Sign- or zero-extends each immediate to XLEN and computes a PC-relative target.
- Sits between ID and EX: a STAGES-deep register pipeline with valid, stall and flush, so decode timing can be retimed without touching the hazard unit.

---
 rtl/imm_gen_pipe.sv | 142 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate decoder with a STAGES-deep register
// pipeline between decode and execute.
//
// Ports:
//   CLK, RESET    clock (rising edge) / asynchronous active-high reset
//   IN_VALID      INSTRUCTION, SELECT, IN_PC are valid this cycle
//   INSTRUCTION   raw 32-bit instruction word
//   SELECT        immediate format: 0 U, 1 J, 2 I, 3 B, 4 S, 5 SHAMT, 6 ZIMM
//   IN_PC         PC of the instruction
//   STALL         hold every stage, inputs not consumed
//   FLUSH         clear every stage (overrides STALL)
//   OUT_VALID     OUT_IMM / OUT_TARGET valid
//   OUT_IMM       extended immediate
//   OUT_TARGET    IN_PC + immediate, wrapping modulo 2^XLEN
//
// Outputs come straight from the last stage register. There is no
// combinational path from any input to any output.

// One pipeline stage: {valid, imm, target} with hold and clear.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            stall,
  input  logic            flush,
  input  logic            d_vld,
  input  logic [XLEN-1:0] d_imm,
  input  logic [XLEN-1:0] d_tgt,
  output logic            q_vld,
  output logic [XLEN-1:0] q_imm,
  output logic [XLEN-1:0] q_tgt
);
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_vld <= 1'b0;
      q_imm <= '0;
      q_tgt <= '0;
    end else if (flush) begin
      q_vld <= 1'b0;
      q_imm <= '0;
      q_tgt <= '0;
    end else if (!stall) begin
      q_vld <= d_vld;
      q_imm <= d_imm;
      q_tgt <= d_tgt;
    end
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int SEL_W  = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  input  logic [31:0]      INSTRUCTION,
  input  logic [SEL_W-1:0] SELECT,
  input  logic [XLEN-1:0]  IN_PC,
  input  logic             STALL,
  input  logic             FLUSH,
  output logic             OUT_VALID,
  output logic [XLEN-1:0]  OUT_IMM,
  output logic [XLEN-1:0]  OUT_TARGET
);
  localparam logic [SEL_W-1:0] SEL_U     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_J     = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_I     = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_B     = SEL_W'(3);
  localparam logic [SEL_W-1:0] SEL_S     = SEL_W'(4);
  localparam logic [SEL_W-1:0] SEL_SHAMT = SEL_W'(5);
  localparam logic [SEL_W-1:0] SEL_ZIMM  = SEL_W'(6);

  // Sign-extend a 32-bit value to XLEN (XLEN >= 32 keeps the count >= 1).
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  logic            s;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] tgt;

  // Opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^INSTRUCTION[6:0];

  assign s     = INSTRUCTION[31];
  // RV64 shifts take a 6-bit amount; RV32 only 5.
  assign shamt = (XLEN == 64) ? INSTRUCTION[25:20] : {1'b0, INSTRUCTION[24:20]};

  // Unlisted encodings and any X/Z in SELECT fall to the default (zero).
  always_comb begin
    imm = '0;
    case (SELECT)
      SEL_U:     imm = sext32({INSTRUCTION[31:12], 12'b0});
      SEL_J:     imm = sext32({{11{s}}, INSTRUCTION[31], INSTRUCTION[19:12],
                               INSTRUCTION[20], INSTRUCTION[30:21], 1'b0});
      SEL_I:     imm = sext32({{20{s}}, INSTRUCTION[31:20]});
      SEL_B:     imm = sext32({{19{s}}, INSTRUCTION[31], INSTRUCTION[7],
                               INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0});
      SEL_S:     imm = sext32({{20{s}}, INSTRUCTION[31:25], INSTRUCTION[11:7]});
      SEL_SHAMT: imm = {{(XLEN-6){1'b0}}, shamt};
      SEL_ZIMM:  imm = {{(XLEN-5){1'b0}}, INSTRUCTION[19:15]};
      default:   imm = '0;
    endcase
  end

  // Carry-out is dropped: the target wraps modulo 2^XLEN.
  assign tgt = IN_PC + imm;

  // Element 0 is the decode result; element k is the output of stage k.
  logic [STAGES:0]           vld_pipe;
  logic [STAGES:0][XLEN-1:0] imm_pipe;
  logic [STAGES:0][XLEN-1:0] tgt_pipe;

  // Bubbles enter as all-zero so invalid outputs always read zero.
  assign vld_pipe[0] = IN_VALID;
  assign imm_pipe[0] = IN_VALID ? imm : '0;
  assign tgt_pipe[0] = IN_VALID ? tgt : '0;

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    imm_gen_stage #(.XLEN(XLEN)) u_stage (
      .CLK   (CLK),
      .RESET (RESET),
      .stall (STALL),
      .flush (FLUSH),
      .d_vld (vld_pipe[g-1]),
      .d_imm (imm_pipe[g-1]),
      .d_tgt (tgt_pipe[g-1]),
      .q_vld (vld_pipe[g]),
      .q_imm (imm_pipe[g]),
      .q_tgt (tgt_pipe[g])
    );
  end

  assign OUT_VALID  = vld_pipe[STAGES];
  assign OUT_IMM    = imm_pipe[STAGES];
  assign OUT_TARGET = tgt_pipe[STAGES];
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a decode vector table on 1-stage
// 32- and 64-bit instances, then hand-written sequences on a 3-stage
// instance for latency, stall, flush and asynchronous reset.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [31:0] ins;
  logic [2:0]  sel;
  logic [31:0] pc32;
  logic [63:0] pc64;
  logic        stall, flush;

  logic        v1, v64, v3;
  logic [31:0] i1, t1, i3, t3;
  logic [63:0] i64, t64;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) d1 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv), .INSTRUCTION(ins), .SELECT(sel),
    .IN_PC(pc32), .STALL(stall), .FLUSH(flush),
    .OUT_VALID(v1), .OUT_IMM(i1), .OUT_TARGET(t1));

  imm_gen_pipe #(.XLEN(64), .STAGES(1)) d64 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv), .INSTRUCTION(ins), .SELECT(sel),
    .IN_PC(pc64), .STALL(stall), .FLUSH(flush),
    .OUT_VALID(v64), .OUT_IMM(i64), .OUT_TARGET(t64));

  imm_gen_pipe #(.XLEN(32), .STAGES(3)) d3 (
    .CLK(clk), .RESET(rst), .IN_VALID(iv), .INSTRUCTION(ins), .SELECT(sel),
    .IN_PC(pc32), .STALL(stall), .FLUSH(flush),
    .OUT_VALID(v3), .OUT_IMM(i3), .OUT_TARGET(t3));

  typedef struct {
    logic        iv;
    logic [31:0] ins;
    logic [2:0]  sel;
    logic [31:0] pc;
    logic [31:0] ei;
    logic [31:0] et;
    logic        c64;
    logic [63:0] ei64;
    logic [63:0] et64;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] w, input logic [2:0] s,
                     input logic [31:0] p, input logic st, input logic fl);
    iv = v; ins = w; sel = s; pc32 = p; pc64 = {32'b0, p}; stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // I-type word whose immediate is the positive 12-bit value k.
  function automatic logic [31:0] itype(input int k);
    logic [11:0] f;
    f = 12'(k);
    return {f, 20'h00013};
  endfunction

  // Drive entry k (I-type, PC 0x1000) or a bubble when k < 0.
  task automatic drv_entry(input int k, input logic st, input logic fl);
    if (k >= 0) drv(1'b1, itype(k), 3'd2, 32'h1000, st, fl);
    else        drv(1'b0, 32'h0, 3'd2, 32'h1000, st, fl);
  endtask

  // Check the 3-stage outputs against entry k, or against a bubble.
  task automatic chk3(input string nm, input int k);
    if (k >= 0) begin
      chk({nm, ".v"}, {63'b0, v3}, 64'd1);
      chk({nm, ".imm"}, {32'b0, i3}, 64'(k));
      chk({nm, ".tgt"}, {32'b0, t3}, 64'(32'h1000 + k));
    end else begin
      chk({nm, ".v"}, {63'b0, v3}, 64'd0);
      chk({nm, ".imm"}, {32'b0, i3}, 64'd0);
      chk({nm, ".tgt"}, {32'b0, t3}, 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int drv_s[11], st_s[11], exp_s[11];
    int drv_f[11], fl_f[11], exp_f[11];

    vt[0]  = '{1'b1, 32'h53a4c063, 3'd0, 32'h1000, 32'h53a4c000, 32'h53a4d000,
               1'b1, 64'h53a4c000, 64'h53a4d000};
    vt[1]  = '{1'b1, 32'hfe800013, 3'd2, 32'h1000, 32'hffffffe8, 32'h00000fe8,
               1'b1, 64'hffffffffffffffe8, 64'h0000000000000fe8};
    vt[2]  = '{1'b1, 32'hdaee306f, 3'd1, 32'h1000, 32'hfffe35ae, 32'hfffe45ae,
               1'b1, 64'hfffffffffffe35ae, 64'hfffffffffffe45ae};
    vt[3]  = '{1'b1, 32'h94000de3, 3'd3, 32'h1000, 32'hfffff95a, 32'h0000095a,
               1'b0, 64'h0, 64'h0};
    vt[4]  = '{1'b1, 32'h94000523, 3'd4, 32'h1000, 32'hfffff94a, 32'h0000094a,
               1'b0, 64'h0, 64'h0};
    vt[5]  = '{1'b1, 32'h01f01013, 3'd5, 32'h1000, 32'h0000001f, 32'h0000101f,
               1'b1, 64'h1f, 64'h101f};
    vt[6]  = '{1'b1, 32'h03f01013, 3'd5, 32'h1000, 32'h0000001f, 32'h0000101f,
               1'b1, 64'h3f, 64'h103f};
    vt[7]  = '{1'b1, 32'h000fd073, 3'd6, 32'h1000, 32'h0000001f, 32'h0000101f,
               1'b1, 64'h1f, 64'h101f};
    vt[8]  = '{1'b1, 32'hfe800013, 3'd7, 32'h1000, 32'h0, 32'h1000,
               1'b1, 64'h0, 64'h1000};
    vt[9]  = '{1'b1, 32'h00000fff, 3'bxxx, 32'h1000, 32'h0, 32'h1000,
               1'b1, 64'h0, 64'h1000};
    vt[10] = '{1'b1, 32'h02000013, 3'd2, 32'hfffffff0, 32'h20, 32'h00000010,
               1'b1, 64'h20, 64'h0000000100000010};
    vt[11] = '{1'b0, 32'hfe800013, 3'd2, 32'h1000, 32'h0, 32'h0,
               1'b1, 64'h0, 64'h0};
    vt[12] = '{1'b1, 32'h80000037, 3'd0, 32'h1000, 32'h80000000, 32'h80001000,
               1'b1, 64'hffffffff80000000, 64'hffffffff80001000};

    // Stall mid-stream: entry 3 is held for two stalled edges.
    drv_s = '{0, 1, 2, 3, 3, 3, 4, 5, -1, -1, -1};
    st_s  = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    exp_s = '{-1, -1, 0, 0, 0, 1, 2, 3, 4, 5, -1};
    // Flush with stall on a full pipe, then one fresh entry.
    drv_f = '{0, 1, 2, 3, -1, -1, -1, 4, -1, -1, -1};
    fl_f  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    exp_f = '{-1, -1, 0, -1, -1, -1, -1, -1, -1, 4, -1};

    rst = 1'b1;
    drv(1'b1, 32'hfe800013, 3'd2, 32'h1000, 1'b0, 1'b0);
    #1;
    chk("rst.v1", {63'b0, v1}, 64'd0);
    chk("rst.i1", {32'b0, i1}, 64'd0);
    chk("rst.t64", t64, 64'd0);
    chk("rst.v3", {63'b0, v3}, 64'd0);
    chk("rst.t3", {32'b0, t3}, 64'd0);
    tick();
    chk("rst_edge.v1", {63'b0, v1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table, one vector per cycle, visible one cycle after capture.
    for (int i = 0; i < 13; i++) begin
      drv(vt[i].iv, vt[i].ins, vt[i].sel, vt[i].pc, 1'b0, 1'b0);
      tick();
      chk($sformatf("vec%0d.v", i), {63'b0, v1}, {63'b0, vt[i].iv});
      chk($sformatf("vec%0d.imm", i), {32'b0, i1}, {32'b0, vt[i].ei});
      chk($sformatf("vec%0d.tgt", i), {32'b0, t1}, {32'b0, vt[i].et});
      if (vt[i].c64) begin
        chk($sformatf("vec%0d.v64", i), {63'b0, v64}, {63'b0, vt[i].iv});
        chk($sformatf("vec%0d.imm64", i), i64, vt[i].ei64);
        chk($sformatf("vec%0d.tgt64", i), t64, vt[i].et64);
      end
    end

    for (int i = 0; i < 3; i++) begin
      drv_entry(-1, 1'b0, 1'b0);
      tick();
    end

    // Five back-to-back entries through 3 stages: visible after edges 3..7.
    for (int e = 1; e <= 9; e++) begin
      drv_entry((e <= 5) ? 16 * e : -1, 1'b0, 1'b0);
      tick();
      chk3($sformatf("b2b.e%0d", e), (e >= 3 && e <= 7) ? 16 * (e - 2) : -1);
    end

    for (int e = 0; e < 11; e++) begin
      drv_entry((drv_s[e] >= 0) ? 256 + drv_s[e] : -1, st_s[e] != 0, 1'b0);
      tick();
      chk3($sformatf("stall.e%0d", e + 1), (exp_s[e] >= 0) ? 256 + exp_s[e] : -1);
    end

    for (int e = 0; e < 11; e++) begin
      drv_entry((drv_f[e] >= 0) ? 512 + drv_f[e] : -1, fl_f[e] != 0, fl_f[e] != 0);
      tick();
      chk3($sformatf("flush.e%0d", e + 1), (exp_f[e] >= 0) ? 512 + exp_f[e] : -1);
    end

    // Fill the pipe, then reset asynchronously between edges.
    for (int e = 0; e < 3; e++) begin
      drv_entry(768 + e, 1'b0, 1'b0);
      tick();
    end
    chk3("pre_rst", 768);
    #3;
    rst = 1'b1;
    #1;
    chk3("async_rst", -1);
    chk("async_rst.v1", {63'b0, v1}, 64'd0);
    chk("async_rst.i1", {32'b0, i1}, 64'd0);
    chk("async_rst.i64", i64, 64'd0);
    #1;
    rst = 1'b0;
    drv_entry(800, 1'b0, 1'b0);
    tick();
    chk3("post_rst.e1", -1);
    drv_entry(-1, 1'b0, 1'b0);
    tick();
    chk3("post_rst.e2", -1);
    tick();
    chk3("post_rst.e3", 800);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
